// File: rtl/nibble_word_packer_if.sv
// Purpose : bundles the nibble input strobe, control pulses and word output handshake of nibble_word_packer.
// Latency : none, this is wiring only.
// Backpressure: out_ready stalls the word output; the nibble input has no backpressure.
// Ports:
//   master modport : drives inp_valid/inp_data/flush/clr_ovf/out_ready, observes the word side.
//   slave modport  : the packer; consumes nibbles, presents out_valid/out_data/out_partial/overflow/fifo_level.
interface nibble_word_packer_if #(
  parameter int NIBBLES_PER_WORD = 4,
  parameter int FIFO_DEPTH       = 4
);
  localparam int W  = 4 * NIBBLES_PER_WORD;
  localparam int LW = $clog2(FIFO_DEPTH + 1);

  logic          inp_valid;
  logic [3:0]    inp_data;
  logic          flush;
  logic          clr_ovf;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic          out_partial;
  logic          overflow;
  logic [LW-1:0] fifo_level;

  modport master (
    output inp_valid, inp_data, flush, clr_ovf, out_ready,
    input  out_valid, out_data, out_partial, overflow, fifo_level
  );

  modport slave (
    input  inp_valid, inp_data, flush, clr_ovf, out_ready,
    output out_valid, out_data, out_partial, overflow, fifo_level
  );
endinterface

// File: rtl/nibble_word_packer.sv
// Purpose : packs a no-backpressure nibble stream into NIBBLES_PER_WORD-nibble words, buffered in a small FIFO.
// Latency : a word is visible on out_valid/out_data one cycle after its completing nibble or flush (FIFO empty).
// Backpressure: out_ready stalls the FIFO head; a completed word arriving at a full FIFO is dropped and sets overflow.
// Ports:
//   clk, rstb : rising-edge clock, asynchronous active-low reset.
//   bus       : slave side of nibble_word_packer_if (nibble input, flush, clr_ovf, word output, status).
module nibble_word_packer #(
  parameter int NIBBLES_PER_WORD = 4,
  parameter int FIFO_DEPTH       = 4,
  parameter bit MSB_FIRST        = 1'b1
) (
  input logic             clk,
  input logic             rstb,
  nibble_word_packer_if.slave bus
);
  localparam int N  = NIBBLES_PER_WORD;
  localparam int W  = 4 * N;
  localparam int CW = $clog2(N);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(FIFO_DEPTH + 1);

  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
  localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);

  // Word assembly
  logic [CW-1:0] cnt_q;
  logic [W-1:0]  asm_q;
  logic [CW-1:0] slot;
  logic [W-1:0]  nib_shifted;
  logic [W-1:0]  asm_word;
  logic          word_done;
  logic          push;
  logic          push_partial;

  // Output FIFO
  logic [W:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [LW-1:0] level_q;
  logic          ovf_q;
  logic [W:0]    head;
  logic          pop;
  logic          full;
  logic          accept;
  logic          drop;

  // The incoming nibble is merged into the word being pushed, so a flush in
  // the same cycle as a nibble carries that nibble with it.
  always_comb begin
    slot        = MSB_FIRST ? (CNT_LAST - cnt_q) : cnt_q;
    nib_shifted = {{(W-4){1'b0}}, bus.inp_data} << {slot, 2'b00};
    asm_word    = bus.inp_valid ? (asm_q | nib_shifted) : asm_q;
  end

  assign word_done    = bus.inp_valid && (cnt_q == CNT_LAST);
  assign push         = word_done || (bus.flush && ((cnt_q != '0) || bus.inp_valid));
  assign push_partial = !word_done;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      cnt_q <= '0;
      asm_q <= '0;
    end else if (push) begin
      cnt_q <= '0;
      asm_q <= '0;
    end else if (bus.inp_valid) begin
      cnt_q <= cnt_q + CW'(1);
      asm_q <= asm_word;
    end
  end

  // A pop frees the head slot in the same cycle, so a push into a full FIFO
  // alongside a pop is accepted (the write lands where the head was read).
  assign pop    = (level_q != '0) && bus.out_ready;
  assign full   = (level_q == LVL_FULL);
  assign accept = push && (!full || pop);
  assign drop   = push && full && !pop;

  // Storage is not reset: the head is masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_ptr_q] <= {push_partial, asm_word};
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (accept) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({accept, pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
      // A drop in the same cycle as clr_ovf still leaves the flag set.
      if (drop) begin
        ovf_q <= 1'b1;
      end else if (bus.clr_ovf) begin
        ovf_q <= 1'b0;
      end
    end
  end

  assign head            = mem[rd_ptr_q];
  assign bus.out_valid   = (level_q != '0);
  assign bus.out_data    = bus.out_valid ? head[W-1:0] : '0;
  assign bus.out_partial = bus.out_valid & head[W];
  assign bus.overflow    = ovf_q;
  assign bus.fifo_level  = level_q;
endmodule

// File: tb/tb_nibble_word_packer.sv
// Purpose : self-checking bench for nibble_word_packer (MSB_FIRST=1 and MSB_FIRST=0 instances).
// Latency : inputs are driven and outputs sampled 1 ns after each rising edge.
// Backpressure: out_ready is driven per test, including long stalls that fill the FIFO.
`timescale 1ns/1ps
module tb_nibble_word_packer;
  localparam int N     = 4;
  localparam int DEPTH = 4;

  logic clk  = 1'b0;
  logic rstb = 1'b0;
  always #5 clk = ~clk;

  nibble_word_packer_if #(.NIBBLES_PER_WORD(N), .FIFO_DEPTH(DEPTH)) bus0 ();
  nibble_word_packer_if #(.NIBBLES_PER_WORD(N), .FIFO_DEPTH(DEPTH)) bus1 ();

  nibble_word_packer #(.NIBBLES_PER_WORD(N), .FIFO_DEPTH(DEPTH), .MSB_FIRST(1'b1)) dut0 (
    .clk(clk), .rstb(rstb), .bus(bus0)
  );
  nibble_word_packer #(.NIBBLES_PER_WORD(N), .FIFO_DEPTH(DEPTH), .MSB_FIRST(1'b0)) dut1 (
    .clk(clk), .rstb(rstb), .bus(bus1)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        v;
    logic [3:0]  d;
    logic        f;
    logic        r;
    logic        ev;
    logic [15:0] ed;
    logic        ep;
  } vec_t;

  vec_t tbl [22];

  // Reference model state: nibbles of the word in progress, stored words.
  logic [3:0]  m_cur [$];
  logic [16:0] m_fifo [$];
  logic        m_ovf;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus0.inp_valid = 1'b0; bus0.inp_data = 4'h0; bus0.flush = 1'b0; bus0.clr_ovf = 1'b0;
    bus1.inp_valid = 1'b0; bus1.inp_data = 4'h0; bus1.flush = 1'b0; bus1.clr_ovf = 1'b0;
  endtask

  task automatic feed0(input logic [3:0] nib);
    bus0.inp_valid = 1'b1;
    bus0.inp_data  = nib;
    cyc();
    bus0.inp_valid = 1'b0;
  endtask

  task automatic feed1(input logic [3:0] nib);
    bus1.inp_valid = 1'b1;
    bus1.inp_data  = nib;
    cyc();
    bus1.inp_valid = 1'b0;
  endtask

  function automatic vec_t mk(input logic v, input logic [3:0] d, input logic f, input logic r,
                              input logic ev, input logic [15:0] ed, input logic ep);
    vec_t t;
    t.v = v; t.d = d; t.f = f; t.r = r; t.ev = ev; t.ed = ed; t.ep = ep;
    return t;
  endfunction

  task automatic do_reset();
    idle_inputs();
    rstb = 1'b0;
    cyc();
    cyc();
    rstb = 1'b1;
    m_cur.delete();
    m_fifo.delete();
    m_ovf = 1'b0;
  endtask

  // One randomized cycle on instance sel, followed by a model step and comparison.
  task automatic rand_step(input int sel);
    logic        v, f, c, r, msb, pop, complete, push, was_full, drop;
    logic [3:0]  d;
    int unsigned word;
    int          pos;
    logic        a_valid, a_partial, a_ovf;
    logic [15:0] a_data;
    logic [2:0]  a_level;
    logic [15:0] e_data;
    logic        e_partial;

    v = ($urandom_range(0, 9) < 6);
    d = 4'($urandom_range(0, 15));
    f = ($urandom_range(0, 9) == 0);
    c = ($urandom_range(0, 19) == 0);
    r = ($urandom_range(0, 9) < 4);
    msb = (sel == 0);
    if (sel == 0) begin
      bus0.inp_valid = v; bus0.inp_data = d; bus0.flush = f; bus0.clr_ovf = c; bus0.out_ready = r;
    end else begin
      bus1.inp_valid = v; bus1.inp_data = d; bus1.flush = f; bus1.clr_ovf = c; bus1.out_ready = r;
    end
    cyc();

    pop      = (m_fifo.size() > 0) && r;
    complete = v && (m_cur.size() == N - 1);
    push     = complete || (f && (m_cur.size() > 0 || v));
    was_full = (m_fifo.size() == DEPTH);
    drop     = 1'b0;
    if (v) m_cur.push_back(d);
    word = 0;
    if (push) begin
      for (int k = 0; k < m_cur.size(); k++) begin
        pos  = msb ? (N - 1 - k) : k;
        word = word + int'(m_cur[k]) * (16 ** pos);
      end
    end
    if (pop) void'(m_fifo.pop_front());
    if (push) begin
      if (!was_full || pop) m_fifo.push_back({!complete, 16'(word)});
      else drop = 1'b1;
      m_cur.delete();
    end
    m_ovf = drop ? 1'b1 : (c ? 1'b0 : m_ovf);

    if (sel == 0) begin
      a_valid = bus0.out_valid; a_data = bus0.out_data; a_partial = bus0.out_partial;
      a_ovf = bus0.overflow; a_level = bus0.fifo_level;
    end else begin
      a_valid = bus1.out_valid; a_data = bus1.out_data; a_partial = bus1.out_partial;
      a_ovf = bus1.overflow; a_level = bus1.fifo_level;
    end
    e_data    = (m_fifo.size() > 0) ? m_fifo[0][15:0] : 16'h0;
    e_partial = (m_fifo.size() > 0) ? m_fifo[0][16] : 1'b0;
    chk($sformatf("rnd%0d_valid", sel), 32'(a_valid), 32'(m_fifo.size() > 0));
    chk($sformatf("rnd%0d_data", sel), 32'(a_data), 32'(e_data));
    chk($sformatf("rnd%0d_partial", sel), 32'(a_partial), 32'(e_partial));
    chk($sformatf("rnd%0d_level", sel), 32'(a_level), 32'(m_fifo.size()));
    chk($sformatf("rnd%0d_overflow", sel), 32'(a_ovf), 32'(m_ovf));
  endtask

  initial begin
    logic [15:0] t3 [4];
    logic [15:0] t4 [4];
    t3[0] = 16'h0123; t3[1] = 16'h4567; t3[2] = 16'h89AB; t3[3] = 16'hCDEF;
    t4[0] = 16'h2222; t4[1] = 16'h3333; t4[2] = 16'h4444; t4[3] = 16'h5555;

    // Basic packing and flush behaviour (MSB_FIRST=1), one row per cycle.
    tbl[0]  = mk(1, 4'h1, 0, 1, 0, 16'h0000, 0);
    tbl[1]  = mk(1, 4'h2, 0, 1, 0, 16'h0000, 0);
    tbl[2]  = mk(1, 4'h3, 0, 1, 0, 16'h0000, 0);
    tbl[3]  = mk(1, 4'h4, 0, 1, 1, 16'h1234, 0);
    tbl[4]  = mk(0, 4'h0, 0, 1, 0, 16'h0000, 0);
    tbl[5]  = mk(1, 4'hA, 0, 1, 0, 16'h0000, 0);
    tbl[6]  = mk(0, 4'h0, 0, 1, 0, 16'h0000, 0);
    tbl[7]  = mk(0, 4'h0, 0, 1, 0, 16'h0000, 0);
    tbl[8]  = mk(0, 4'h0, 0, 1, 0, 16'h0000, 0);
    tbl[9]  = mk(1, 4'hB, 0, 1, 0, 16'h0000, 0);
    tbl[10] = mk(0, 4'h0, 1, 1, 1, 16'hAB00, 1);
    tbl[11] = mk(0, 4'h0, 1, 1, 0, 16'h0000, 0);
    tbl[12] = mk(0, 4'h0, 0, 1, 0, 16'h0000, 0);
    tbl[13] = mk(1, 4'hA, 0, 1, 0, 16'h0000, 0);
    tbl[14] = mk(1, 4'hB, 0, 1, 0, 16'h0000, 0);
    tbl[15] = mk(1, 4'hC, 1, 1, 1, 16'hABC0, 1);
    tbl[16] = mk(0, 4'h0, 0, 1, 0, 16'h0000, 0);
    tbl[17] = mk(1, 4'h1, 0, 1, 0, 16'h0000, 0);
    tbl[18] = mk(1, 4'h2, 0, 1, 0, 16'h0000, 0);
    tbl[19] = mk(1, 4'h3, 0, 1, 0, 16'h0000, 0);
    tbl[20] = mk(1, 4'h4, 1, 1, 1, 16'h1234, 0);
    tbl[21] = mk(0, 4'h0, 0, 1, 0, 16'h0000, 0);

    // Reset state
    idle_inputs();
    bus0.out_ready = 1'b1;
    bus1.out_ready = 1'b1;
    m_ovf = 1'b0;
    #3;
    chk("rst_valid0", 32'(bus0.out_valid), 32'h0);
    chk("rst_data0", 32'(bus0.out_data), 32'h0);
    chk("rst_level0", 32'(bus0.fifo_level), 32'h0);
    chk("rst_ovf0", 32'(bus0.overflow), 32'h0);
    chk("rst_valid1", 32'(bus1.out_valid), 32'h0);
    do_reset();

    for (int i = 0; i < 22; i++) begin
      bus0.inp_valid = tbl[i].v;
      bus0.inp_data  = tbl[i].d;
      bus0.flush     = tbl[i].f;
      bus0.out_ready = tbl[i].r;
      cyc();
      chk($sformatf("tbl%0d_valid", i), 32'(bus0.out_valid), 32'(tbl[i].ev));
      chk($sformatf("tbl%0d_data", i), 32'(bus0.out_data), 32'(tbl[i].ed));
      chk($sformatf("tbl%0d_partial", i), 32'(bus0.out_partial), 32'(tbl[i].ep));
    end
    idle_inputs();

    // Overflow with a stalled consumer, then in-order drain
    bus0.out_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      feed0(4'(i % 16));
      if (i == 15) begin
        chk("ovf_full_level", 32'(bus0.fifo_level), 32'd4);
        chk("ovf_not_yet", 32'(bus0.overflow), 32'h0);
      end
    end
    chk("ovf_level", 32'(bus0.fifo_level), 32'd4);
    chk("ovf_set", 32'(bus0.overflow), 32'h1);
    bus0.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("ovf_drain%0d_valid", k), 32'(bus0.out_valid), 32'h1);
      chk($sformatf("ovf_drain%0d_data", k), 32'(bus0.out_data), 32'(t3[k]));
      cyc();
    end
    chk("ovf_drain_empty", 32'(bus0.out_valid), 32'h0);
    cyc();
    chk("ovf_sticky", 32'(bus0.overflow), 32'h1);
    bus0.clr_ovf = 1'b1;
    cyc();
    bus0.clr_ovf = 1'b0;
    chk("ovf_cleared", 32'(bus0.overflow), 32'h0);

    // Full FIFO: push alongside pop succeeds; drop beats clr_ovf
    bus0.out_ready = 1'b0;
    for (int w = 1; w <= 4; w++) begin
      for (int k = 0; k < 4; k++) feed0(4'(w));
    end
    for (int k = 0; k < 3; k++) feed0(4'h5);
    bus0.out_ready = 1'b1;
    feed0(4'h5);
    bus0.out_ready = 1'b0;
    chk("pp_level", 32'(bus0.fifo_level), 32'd4);
    chk("pp_no_ovf", 32'(bus0.overflow), 32'h0);
    chk("pp_head", 32'(bus0.out_data), 32'h2222);
    for (int k = 0; k < 3; k++) feed0(4'h6);
    bus0.clr_ovf = 1'b1;
    feed0(4'h6);
    bus0.clr_ovf = 1'b0;
    chk("drop_vs_clr_ovf", 32'(bus0.overflow), 32'h1);
    chk("drop_level", 32'(bus0.fifo_level), 32'd4);
    bus0.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("pp_drain%0d", k), 32'(bus0.out_data), 32'(t4[k]));
      cyc();
    end
    chk("pp_drain_empty", 32'(bus0.out_valid), 32'h0);
    bus0.clr_ovf = 1'b1;
    cyc();
    bus0.clr_ovf = 1'b0;

    // Reset mid-word discards the partial word and the stored words
    bus0.out_ready = 1'b0;
    for (int k = 0; k < 4; k++) feed0(4'hE);
    chk("mr_pending", 32'(bus0.out_valid), 32'h1);
    feed0(4'h5);
    feed0(4'h6);
    rstb = 1'b0;
    #1;
    chk("mr_valid", 32'(bus0.out_valid), 32'h0);
    chk("mr_data", 32'(bus0.out_data), 32'h0);
    chk("mr_partial", 32'(bus0.out_partial), 32'h0);
    chk("mr_level", 32'(bus0.fifo_level), 32'h0);
    chk("mr_ovf", 32'(bus0.overflow), 32'h0);
    cyc();
    rstb = 1'b1;
    bus0.out_ready = 1'b1;
    feed0(4'h7);
    feed0(4'h8);
    feed0(4'h9);
    feed0(4'hA);
    chk("mr_word_valid", 32'(bus0.out_valid), 32'h1);
    chk("mr_word_data", 32'(bus0.out_data), 32'h789A);
    cyc();
    chk("mr_only_one", 32'(bus0.out_valid), 32'h0);

    // LSB-first packing with random gaps and stalls
    bus1.out_ready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      int g;
      g = $urandom_range(0, 3);
      repeat (g) cyc();
      feed1(4'(k));
    end
    chk("lsb_valid", 32'(bus1.out_valid), 32'h1);
    chk("lsb_data", 32'(bus1.out_data), 32'h4321);
    chk("lsb_partial", 32'(bus1.out_partial), 32'h0);
    begin
      int s;
      s = $urandom_range(1, 4);
      for (int k = 0; k < s; k++) begin
        cyc();
        chk("lsb_hold_valid", 32'(bus1.out_valid), 32'h1);
        chk("lsb_hold_data", 32'(bus1.out_data), 32'h4321);
      end
    end
    bus1.out_ready = 1'b1;
    cyc();
    chk("lsb_popped", 32'(bus1.out_valid), 32'h0);

    // Randomized run against the reference model, both packing orders
    for (int sel = 0; sel < 2; sel++) begin
      do_reset();
      for (int n = 0; n < 400; n++) rand_step(sel);
      idle_inputs();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
